// File: rtl/popcount_pipe.sv
// popcount_pipe: fully pipelined masked population counter with a registered
// binary adder tree and a saturating per-frame running total.
module popcount_pipe #(
    parameter int DATA_W = 128,
    parameter int ACC_W  = 16,
    localparam int LVL   = $clog2(DATA_W),
    localparam int CNT_W = LVL + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_mask,
    input  logic              in_mode,
    input  logic              in_last,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic              out_last
);

    // Valid/last travel alongside the tree; index k marks tree level k.
    logic [LVL-1:0]   vld_p;
    logic [LVL-1:0]   last_p;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_final;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_ovf;

    // Saturating add of a beat count onto the frame total; returns {overflow, clamped}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [CNT_W-1:0] cnt);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(cnt);
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return sum;
    endfunction

    // Valid/last shift chain; a flush empties every stage and drops the incoming beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            last_p <= '0;
        end else if (soft_clr) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= in_valid;
            last_p[0] <= in_valid & in_last;
            for (int j = 1; j < LVL; j++) begin
                vld_p[j]  <= vld_p[j-1];
                last_p[j] <= last_p[j-1];
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < LVL; k++) begin : g_lvl
            localparam int N = DATA_W >> k;
            localparam int W = k + 1;
            logic [W-1:0] sum_p [N];

            if (k == 0) begin : g_leaf
                // ---- stage 0: masked, mode-adjusted operand bits ----
                // Leaf register captures one operand bit per lane on each valid beat.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < N; i++) sum_p[i] <= '0;
                    end else if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            sum_p[i] <= (in_data[i] ^ in_mode) & in_mask[i];
                        end
                    end
                end
            end else begin : g_node
                // ---- stage k: pairwise sums of level k-1, one bit wider ----
                // Node register adds neighbouring lower-level sums while that stage holds a beat.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < N; i++) sum_p[i] <= '0;
                    end else if (vld_p[k-1]) begin
                        for (int i = 0; i < N; i++) begin
                            sum_p[i] <= {1'b0, g_lvl[k-1].sum_p[2*i]}
                                      + {1'b0, g_lvl[k-1].sum_p[2*i+1]};
                        end
                    end
                end
            end
        end
    endgenerate

    // ---- final stage: last pair add feeds the registered outputs directly ----
    assign cnt_final          = {1'b0, g_lvl[LVL-1].sum_p[0]} + {1'b0, g_lvl[LVL-1].sum_p[1]};
    assign {acc_ovf, acc_sum} = sat_add(acc_q, cnt_final);

    // Output register and frame accumulator; outputs read zero on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
            out_last  <= 1'b0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
        end else if (soft_clr) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
            out_last  <= 1'b0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
        end else if (vld_p[LVL-1]) begin
            out_valid <= 1'b1;
            out_count <= cnt_final;
            out_acc   <= acc_sum;
            out_sat   <= sat_q | acc_ovf;
            out_last  <= last_p[LVL-1];
            if (last_p[LVL-1]) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else begin
                acc_q <= acc_sum;
                sat_q <= sat_q | acc_ovf;
            end
        end else begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe: directed and random checks of popcount_pipe across four
// configurations sharing one stimulus stream against a cycle-history model.
module tb_popcount_pipe;

    localparam int NI = 4;
    localparam int WV   [NI] = '{128, 128, 32, 2};
    localparam int ACCV [NI] = '{16, 8, 16, 16};
    localparam int LATV [NI] = '{7, 7, 5, 1};
    localparam int HMAX = 8192;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         soft_clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_mask = '0;
    logic         in_mode = 1'b0;
    logic         in_last = 1'b0;

    logic v0, v1, v2, v3, s0, s1, s2, s3, l0, l1, l2, l3;
    logic [7:0]  c0, c1;
    logic [5:0]  c2;
    logic [1:0]  c3;
    logic [15:0] a0, a2, a3;
    logic [7:0]  a1;

    always #5 clk = ~clk;

    popcount_pipe #(.DATA_W(128), .ACC_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_data(in_data), .in_mask(in_mask), .in_mode(in_mode), .in_last(in_last),
        .out_valid(v0), .out_count(c0), .out_acc(a0), .out_sat(s0), .out_last(l0));
    popcount_pipe #(.DATA_W(128), .ACC_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_data(in_data), .in_mask(in_mask), .in_mode(in_mode), .in_last(in_last),
        .out_valid(v1), .out_count(c1), .out_acc(a1), .out_sat(s1), .out_last(l1));
    popcount_pipe #(.DATA_W(32), .ACC_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_data(in_data[31:0]), .in_mask(in_mask[31:0]), .in_mode(in_mode), .in_last(in_last),
        .out_valid(v2), .out_count(c2), .out_acc(a2), .out_sat(s2), .out_last(l2));
    popcount_pipe #(.DATA_W(2), .ACC_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_data(in_data[1:0]), .in_mask(in_mask[1:0]), .in_mode(in_mode), .in_last(in_last),
        .out_valid(v3), .out_count(c3), .out_acc(a3), .out_sat(s3), .out_last(l3));

    logic [63:0] ov [NI], oc [NI], oa [NI], os [NI], ol [NI];
    assign ov[0] = 64'(v0); assign oc[0] = 64'(c0); assign oa[0] = 64'(a0); assign os[0] = 64'(s0); assign ol[0] = 64'(l0);
    assign ov[1] = 64'(v1); assign oc[1] = 64'(c1); assign oa[1] = 64'(a1); assign os[1] = 64'(s1); assign ol[1] = 64'(l1);
    assign ov[2] = 64'(v2); assign oc[2] = 64'(c2); assign oa[2] = 64'(a2); assign os[2] = 64'(s2); assign ol[2] = 64'(l2);
    assign ov[3] = 64'(v3); assign oc[3] = 64'(c3); assign oa[3] = 64'(a3); assign os[3] = 64'(s3); assign ol[3] = 64'(l3);

    int checks = 0;
    int failures = 0;

    // Reference model: history of accepted beats per clock edge plus last flush edge.
    int           cyc = 0;
    int           last_clr = 0;
    bit           hist_ok   [HMAX];
    bit           hist_last [HMAX];
    bit           hist_mode [HMAX];
    logic [127:0] hist_d    [HMAX];
    logic [127:0] hist_m    [HMAX];
    int           acc_m [NI];
    bit           sat_m [NI];
    logic [63:0]  ev [NI], ec [NI], ea [NI], es [NI], el [NI];

    int t0_c[$], t0_a[$], t0_l[$], t1_a[$], t1_s[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [127:0] d, input logic [127:0] m,
                                input bit mode, input int w);
        logic [127:0] lanes;
        lanes = {128{1'b1}} >> (128 - w);
        return $countones((d ^ {128{mode}}) & m & lanes);
    endfunction

    function automatic logic [127:0] ones(input int n);
        logic [127:0] r;
        r = (n == 0) ? '0 : ({128{1'b1}} >> (128 - n));
        return r;
    endfunction

    task automatic clear_model();
        last_clr = cyc;
        for (int i = 0; i < NI; i++) begin
            acc_m[i] = 0; sat_m[i] = 1'b0;
            ev[i] = 0; ec[i] = 0; ea[i] = 0; es[i] = 0; el[i] = 0;
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_u%0d_valid", ph, i), ov[i], ev[i]);
            chk($sformatf("%s_u%0d_count", ph, i), oc[i], ec[i]);
            chk($sformatf("%s_u%0d_acc",   ph, i), oa[i], ea[i]);
            chk($sformatf("%s_u%0d_sat",   ph, i), os[i], es[i]);
            chk($sformatf("%s_u%0d_last",  ph, i), ol[i], el[i]);
        end
    endtask

    // One clock edge: update the model from the sampled inputs, then check all outputs.
    task automatic step();
        int s, cnt, sum, maxv;
        @(posedge clk);
        cyc++;
        if (cyc >= HMAX) begin
            failures++;
            $display("FAIL history_bound observed=%0d required<%0d", cyc, HMAX);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "history bound exceeded");
        end
        if (!rst_n || soft_clr) begin
            hist_ok[cyc] = 1'b0;
            clear_model();
        end else begin
            hist_ok[cyc]   = in_valid;
            hist_last[cyc] = in_last;
            hist_mode[cyc] = in_mode;
            hist_d[cyc]    = in_data;
            hist_m[cyc]    = in_mask;
            for (int i = 0; i < NI; i++) begin
                ev[i] = 0; ec[i] = 0; ea[i] = 0; es[i] = 0; el[i] = 0;
                s = cyc - LATV[i];
                if (s >= 1 && hist_ok[s] && last_clr < s) begin
                    cnt  = popc(hist_d[s], hist_m[s], hist_mode[s], WV[i]);
                    maxv = (1 << ACCV[i]) - 1;
                    sum  = acc_m[i] + cnt;
                    ev[i] = 1; ec[i] = 64'(cnt); el[i] = 64'(hist_last[s]);
                    es[i] = 64'(sat_m[i] | (sum > maxv));
                    if (sum > maxv) sum = maxv;
                    ea[i] = 64'(sum);
                    if (hist_last[s]) begin
                        acc_m[i] = 0; sat_m[i] = 1'b0;
                    end else begin
                        acc_m[i] = sum; sat_m[i] = es[i][0];
                    end
                end
            end
        end
        #1;
        check_all("cyc");
        if (v0) begin t0_c.push_back(int'(c0)); t0_a.push_back(int'(a0)); t0_l.push_back(int'(l0)); end
        if (v1) begin t1_a.push_back(int'(a1)); t1_s.push_back(int'(s1)); end
    endtask

    task automatic drive(input logic [127:0] d, input logic [127:0] m, input logic mode,
                         input logic last, input logic clr);
        in_valid = 1'b1; in_data = d; in_mask = m; in_mode = mode; in_last = last; soft_clr = clr;
        step();
        in_valid = 1'b0; in_last = 1'b0; soft_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0; soft_clr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_track();
        t0_c.delete(); t0_a.delete(); t0_l.delete(); t1_a.delete(); t1_s.delete();
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("async_rst");
        chk("async_rst_u0_valid", ov[0], 0);
        chk("async_rst_u3_valid", ov[3], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t2c [8] = '{0, 1, 64, 127, 128, 3, 5, 9};
        int t2a [8] = '{0, 1, 65, 192, 320, 323, 328, 337};
        int t4a [4] = '{128, 255, 255, 5};
        int t4s [4] = '{0, 1, 1, 0};
        logic [127:0] all1;
        all1 = {128{1'b1}};
        clear_model();

        // Reset state
        idle(2);
        chk("reset_u0_valid", ov[0], 0);
        chk("reset_u0_acc", oa[0], 0);
        #3 rst_n = 1'b1;

        // T1: full beat, latency 7 on the 128-bit instance
        clear_track();
        drive(all1, all1, 1'b0, 1'b1, 1'b0);
        idle(6);
        chk("t1_not_yet", ov[0], 0);
        idle(1);
        chk("t1_valid", ov[0], 1);
        chk("t1_count", oc[0], 128);
        chk("t1_acc", oa[0], 128);
        idle(2);

        // T2: streaming frame of 8 beats
        clear_track();
        for (int b = 0; b < 8; b++) drive(ones(t2c[b]), all1, 1'b0, b == 7, 1'b0);
        idle(9);
        chk("t2_beats", t0_c.size(), 8);
        for (int b = 0; b < 8 && b < t0_c.size(); b++) begin
            chk($sformatf("t2_count%0d", b), t0_c[b], t2c[b]);
            chk($sformatf("t2_acc%0d", b), t0_a[b], t2a[b]);
            chk($sformatf("t2_last%0d", b), t0_l[b], b == 7);
        end

        // T3: mode and mask
        clear_track();
        drive('0, 128'hFF, 1'b1, 1'b1, 1'b0);
        drive('0, 128'hFF, 1'b0, 1'b1, 1'b0);
        idle(8);
        chk("t3_beats", t0_c.size(), 2);
        if (t0_c.size() == 2) begin
            chk("t3_mode1", t0_c[0], 8);
            chk("t3_mode0", t0_c[1], 0);
        end

        // T4: saturation on the 8-bit accumulator
        clear_track();
        drive(all1, all1, 1'b0, 1'b0, 1'b0);
        drive(all1, all1, 1'b0, 1'b0, 1'b0);
        drive(ones(10), all1, 1'b0, 1'b1, 1'b0);
        drive(ones(5), all1, 1'b0, 1'b1, 1'b0);
        idle(8);
        chk("t4_beats", t1_a.size(), 4);
        for (int b = 0; b < 4 && b < t1_a.size(); b++) begin
            chk($sformatf("t4_acc%0d", b), t1_a[b], t4a[b]);
            chk($sformatf("t4_sat%0d", b), t1_s[b], t4s[b]);
        end

        // T5: soft_clr with beats in flight and one on the clear cycle
        clear_track();
        drive(ones(20), all1, 1'b0, 1'b0, 1'b0);
        drive(ones(30), all1, 1'b0, 1'b0, 1'b0);
        drive(ones(40), all1, 1'b0, 1'b0, 1'b0);
        drive(ones(50), all1, 1'b0, 1'b0, 1'b1);
        idle(10);
        chk("t5_flushed", t0_c.size(), 0);
        drive(ones(9), all1, 1'b0, 1'b0, 1'b0);
        idle(8);
        chk("t5_beats", t0_c.size(), 1);
        if (t0_c.size() == 1) chk("t5_acc", t0_a[0], 9);
        drive(ones(1), all1, 1'b0, 1'b1, 1'b0);
        idle(8);

        // T6: asynchronous reset mid-frame, mid-pipeline
        drive(ones(11), all1, 1'b0, 1'b0, 1'b0);
        drive(ones(12), all1, 1'b0, 1'b0, 1'b0);
        drive(ones(13), all1, 1'b0, 1'b0, 1'b0);
        rst_pulse();
        in_valid = 1'b1; in_data = ones(14); in_mask = all1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        clear_track();
        idle(10);
        chk("t6_no_stale", t0_c.size(), 0);
        drive(ones(7), all1, 1'b0, 1'b0, 1'b0);
        idle(8);
        chk("t6_beats", t0_c.size(), 1);
        if (t0_c.size() == 1) chk("t6_acc", t0_a[0], 7);
        drive(ones(2), all1, 1'b0, 1'b1, 1'b0);
        idle(8);

        // Random stream with valid gaps, flushes and one reset, against the model
        for (int n = 0; n < 700; n++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_mask  = ($urandom_range(0, 3) == 0) ? all1 : {$urandom, $urandom, $urandom, $urandom};
            in_mode  = $urandom_range(0, 1);
            in_last  = ($urandom_range(0, 3) == 0);
            soft_clr = ($urandom_range(0, 59) == 0);
            step();
            if (n == 350) begin
                rst_pulse();
                step();
                rst_n = 1'b1;
            end
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
